piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//   Parallel-in serial-out shifter: the read-out counterpart to the DLatch storage cell.
//   Captures a WIDTH-bit word on a load strobe and presents it one bit per clock on Q/Qn, MSB first.
//   Drives single-wire serial links in the sequential examples; the same stream can feed a shift-in receiver.
// PARAMETERS
//   WIDTH   4   bits per word; legal range 2..16
// PORTS
//   c      input   1      clock; all state updates on rising edge
//   r      input   1      reset, asynchronous, active-high
//   d      input   WIDTH  parallel data word, sampled only when a load is accepted
//   load   input   1      load strobe; accepted on a rising edge of c when busy==0
//   Q      output  1      serial data out, registered
//   Qn     output  1      always ~Q, including during reset
//   busy   output  1      1 while a word is being shifted (SHIFT/PARITY states)
//   done   output  1      single-cycle pulse after the last bit
// BEHAVIOUR
//   Reset (r=1, asynchronous, overrides everything):
//     - state=IDLE, shreg=0, cnt=0
//     - Q=0, Qn=1, busy=0, done=0
//     - Reset mid-word abandons the word and produces no done pulse.
//   States: IDLE, SHIFT, PARITY (only with PARITY_EN), DONE.
//   IDLE:
//     - load=1 -> shreg<=d, Q<=d[WIDTH-1], cnt<=0, busy<=1, state<=SHIFT.
//     - Otherwise Q holds 0.
//   SHIFT:
//     - Each edge: shreg<=shreg<<1, Q<=next bit, cnt<=cnt+1.
//     - After the edge that ends bit WIDTH-1 (cnt==WIDTH-1): state<=PARITY if enabled, else DONE.
//   DONE:
//     - Lasts one cycle: done=1, busy=0, Q=0.
//     - Next state is IDLE.
//   Latency: bit k (k=0 is the MSB) is on Q during cycle k+1 after the load edge.
//     - Frame length is WIDTH cycles, or WIDTH+1 with parity.
//     - done is asserted in the cycle after the last bit.
//   Load while busy=1 is ignored; d is not re-sampled.
//   Load during the DONE cycle is accepted (busy=0):
//     - Next state is SHIFT, giving back-to-back words with a one-cycle gap.
//     - done still pulses in that cycle.
//   cnt is $clog2(WIDTH+1) bits wide and never wraps within a frame. Reset clears it.
// CONFIGURATION
//   PARITY_EN (macro):
//     - Defined: after the last data bit, the PARITY state drives Q = ^word (even parity over the
//       captured word) for one cycle, with busy=1, then goes to DONE.
//     - Undefined: the PARITY state and its logic are absent; SHIFT goes directly to DONE.
// STRUCTURE
//   Package piso_pkg:
//     - state enum/localparams: IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2, DONE=2'd3
//     - PISO_MAX_WIDTH=16
//   Sub-module piso_bit_cell: one async-reset D flip-flop with load mux (parallel load vs. shift-in).
//     - Instantiated WIDTH times to form shreg.
//   The FSM, counter and Q/Qn output register live in the top module.
// TESTING
//   1. r=1 for 2 cycles, then 0 -> Q=0, Qn=1, busy=0, done=0.
//      Hold load=0 for 5 cycles -> outputs unchanged.
//   2. d=4'b1011, load=1 for one edge -> Q = 1,0,1,1 on cycles 1-4, busy=1 on cycles 1-4,
//      done=1 on cycle 5, Q=0 afterwards.
//   3. Load 4'b1011, then d=4'b0000 with load=1 on cycles 2-3 -> stream still 1,0,1,1 (load ignored).
//   4. Load 4'b1100, then load 4'b0011 during the DONE cycle -> Q = 1,1,0,0, gap (Q=0, done=1),
//      then 0,0,1,1.
//   5. Load 4'b1111, assert r in cycle 2 -> Q=0 and busy=0 immediately, no done pulse.
//      Restart then works normally.
//   6. PARITY_EN defined, d=4'b1011 -> Q = 1,0,1,1, then parity bit 1, done on cycle 6.
//      With d=4'b1001 the parity bit is 0.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types for the PISO serializer: FSM state encoding, width limit and parity helper.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } piso_state_t;

  localparam int PISO_MAX_WIDTH = 16;

  // Words narrower than the maximum are zero-extended, which leaves even parity unchanged.
  function automatic logic piso_parity(input logic [PISO_MAX_WIDTH-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/piso_bit_cell.sv
// One stage of the serializer shift register: a D flip-flop that takes either the
// parallel word bit (load) or the neighbouring stage's bit (shift).
module piso_bit_cell (
  input  logic c,
  input  logic r,
  input  logic load_en,
  input  logic shift_en,
  input  logic par_in,
  input  logic ser_in,
  output logic q
);

  always_ff @(posedge c or posedge r) begin
    if (r) begin
      q <= 1'b0;
    end else if (load_en) begin
      q <= par_in;
    end else if (shift_en) begin
      q <= ser_in;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter, MSB first, with a one-cycle done pulse per word.
// Optional trailing even-parity bit when the PARITY_EN macro is defined.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             c,
  input  logic             r,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  output logic             Q,
  output logic             Qn,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  piso_state_t      state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             q_reg;
  logic             busy_reg;
  logic             done_reg;
`ifdef PARITY_EN
  logic             par_reg;
`endif

  logic             load_acc;
  logic             shift_en;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shl;

  // DONE already has busy low, so a load there starts the next word straight away.
  assign load_acc  = load && ((state_reg == IDLE) || (state_reg == DONE));
  assign shift_en  = (state_reg == SHIFT);
  assign shreg_shl = shreg << 1;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    piso_bit_cell u_cell (
      .c        (c),
      .r        (r),
      .load_en  (load_acc),
      .shift_en (shift_en),
      .par_in   (d[gi]),
      .ser_in   (shreg_shl[gi]),
      .q        (shreg[gi])
    );
  end

  always_ff @(posedge c or posedge r) begin
    if (r) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      q_reg     <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (load) begin
            state_reg <= SHIFT;
            cnt_reg   <= '0;
            q_reg     <= d[WIDTH-1];
            busy_reg  <= 1'b1;
`ifdef PARITY_EN
            par_reg   <= piso_parity(PISO_MAX_WIDTH'(d));
`endif
          end else begin
            state_reg <= IDLE;
            q_reg     <= 1'b0;
            busy_reg  <= 1'b0;
          end
        end
        SHIFT: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
`ifdef PARITY_EN
            state_reg <= PARITY;
            q_reg     <= par_reg;
`else
            state_reg <= DONE;
            q_reg     <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
`endif
          end else begin
            // The bit about to land in the MSB stage is the next one on the wire.
            q_reg <= shreg_shl[WIDTH-1];
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          state_reg <= DONE;
          q_reg     <= 1'b0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
        end
`endif
        default: begin
          state_reg <= IDLE;
          q_reg     <= 1'b0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign Q    = q_reg;
  assign Qn   = ~q_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed vector table, async-reset sequence,
// and randomized loads checked against a frame-schedule reference model.
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FL = W + (PAR_EN ? 1 : 0);
  localparam int NR = 400;

  logic         c = 1'b0;
  logic         r = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] d = '0;
  logic         Q, Qn, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  piso_serializer #(.WIDTH(W)) dut (
    .c    (c),
    .r    (r),
    .d    (d),
    .load (load),
    .Q    (Q),
    .Qn   (Qn),
    .busy (busy),
    .done (done)
  );

  always #5 c = ~c;

  typedef struct {
    logic         ld;
    logic [W-1:0] dv;
    logic         q;
    logic         b;
    logic         dn;
    bit           par_only;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic ld, input logic [W-1:0] dv, input logic q,
                              input logic b, input logic dn, input bit po = 1'b0);
    vecs.push_back('{ld, dv, q, b, dn, po});
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic eq, input logic eb, input logic edn);
    chk({tag, " Q"}, Q, eq);
    chk({tag, " Qn"}, Qn, ~eq);
    chk({tag, " busy"}, busy, eb);
    chk({tag, " done"}, done, edn);
  endtask

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  // Loads one word and checks the whole frame: data bits MSB first, optional parity, done, idle.
  task automatic run_frame(input string tag, input logic [W-1:0] word);
    logic [W-1:0] w;
    logic         eq;
    w = word;
    load = 1'b1;
    d = w;
    for (int k = 0; k < FL; k++) begin
      tick();
      load = 1'b0;
      eq = (k < W) ? w[W-1-k] : ^w;
      check_out($sformatf("%s bit%0d", tag, k), eq, 1'b1, 1'b0);
    end
    tick();
    check_out({tag, " done"}, 1'b0, 1'b0, 1'b1);
    tick();
    check_out({tag, " idle"}, 1'b0, 1'b0, 1'b0);
    $display("frame %s d=%b checked", tag, w);
  endtask

  logic         rl[NR];
  logic [W-1:0] rd[NR];
  logic         acc[NR];
  logic         eq_a[NR+FL+2];
  logic         eb_a[NR+FL+2];
  logic         ed_a[NR+FL+2];

  initial begin
    // Test 2: single word 1011.
    add(1, 4'b1011, 1, 1, 0);
    add(0, 4'b1011, 0, 1, 0);
    add(0, 4'b1011, 1, 1, 0);
    add(0, 4'b1011, 1, 1, 0);
    add(0, 4'b1011, 1, 1, 0, 1);
    add(0, 4'b1011, 0, 0, 1);
    add(0, 4'b1011, 0, 0, 0);
    // Test 3: loads while busy are ignored.
    add(1, 4'b1011, 1, 1, 0);
    add(1, 4'b0000, 0, 1, 0);
    add(1, 4'b0000, 1, 1, 0);
    add(0, 4'b0000, 1, 1, 0);
    add(0, 4'b0000, 1, 1, 0, 1);
    add(0, 4'b0000, 0, 0, 1);
    add(0, 4'b0000, 0, 0, 0);
    // Test 4: back-to-back words with a load during the DONE cycle.
    add(1, 4'b1100, 1, 1, 0);
    add(0, 4'b1100, 1, 1, 0);
    add(0, 4'b1100, 0, 1, 0);
    add(0, 4'b1100, 0, 1, 0);
    add(0, 4'b1100, 0, 1, 0, 1);
    add(0, 4'b1100, 0, 0, 1);
    add(1, 4'b0011, 0, 1, 0);
    add(0, 4'b0011, 0, 1, 0);
    add(0, 4'b0011, 1, 1, 0);
    add(0, 4'b0011, 1, 1, 0);
    add(0, 4'b0011, 0, 1, 0, 1);
    add(0, 4'b0011, 0, 0, 1);
    add(0, 4'b0011, 0, 0, 0);
    // Test 6 word: parity bit 0.
    add(1, 4'b1001, 1, 1, 0);
    add(0, 4'b1001, 0, 1, 0);
    add(0, 4'b1001, 0, 1, 0);
    add(0, 4'b1001, 1, 1, 0);
    add(0, 4'b1001, 0, 1, 0, 1);
    add(0, 4'b1001, 0, 0, 1);
    add(0, 4'b1001, 0, 0, 0);

    // Test 1: reset and quiet idle.
    r = 1'b1;
    #1;
    check_out("reset_async", 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge c);
    #1;
    check_out("reset", 1'b0, 1'b0, 1'b0);
    r = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out($sformatf("idle%0d", i), 1'b0, 1'b0, 1'b0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].par_only && !PAR_EN) continue;
      load = vecs[i].ld;
      d    = vecs[i].dv;
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].q, vecs[i].b, vecs[i].dn);
      $display("vec %0d load=%b d=%b -> Q=%b busy=%b done=%b", i, vecs[i].ld, vecs[i].dv,
               Q, busy, done);
    end
    load = 1'b0;

    // Test 5: reset mid-word abandons it without a done pulse.
    load = 1'b1;
    d = 4'b1111;
    tick();
    load = 1'b0;
    check_out("rst_bit0", 1'b1, 1'b1, 1'b0);
    tick();
    check_out("rst_bit1", 1'b1, 1'b1, 1'b0);
    #2 r = 1'b1;
    #1;
    check_out("rst_mid", 1'b0, 1'b0, 1'b0);
    tick();
    check_out("rst_hold", 1'b0, 1'b0, 1'b0);
    r = 1'b0;
    for (int i = 0; i < FL + 2; i++) begin
      tick();
      check_out($sformatf("rst_quiet%0d", i), 1'b0, 1'b0, 1'b0);
    end
    run_frame("restart", 4'b1011);

    // Randomized loads against a schedule model: an accepted load at edge e owns
    // edges e..e+FL-1 (busy), pulses done at e+FL, and the next load is taken from e+FL+1.
    for (int e = 0; e < NR; e++) begin
      rl[e] = ($urandom_range(0, 2) == 0);
      rd[e] = W'($urandom);
      acc[e] = 1'b0;
    end
    for (int e = 0; e < NR + FL + 2; e++) begin
      eq_a[e] = 1'b0;
      eb_a[e] = 1'b0;
      ed_a[e] = 1'b0;
    end
    begin
      int next_ok;
      next_ok = 0;
      for (int e = 0; e < NR; e++) begin
        if (rl[e] && e >= next_ok) begin
          acc[e] = 1'b1;
          for (int k = 0; k < FL; k++) begin
            eq_a[e+k] = (k < W) ? rd[e][W-1-k] : ^rd[e];
            eb_a[e+k] = 1'b1;
          end
          ed_a[e+FL] = 1'b1;
          next_ok = e + FL + 1;
        end
      end
    end
    for (int e = 0; e < NR + FL + 2; e++) begin
      load = (e < NR) ? rl[e] : 1'b0;
      d    = (e < NR) ? rd[e] : W'($urandom);
      tick();
      check_out($sformatf("rnd%0d", e), eq_a[e], eb_a[e], ed_a[e]);
      if (e < NR && acc[e])
        $display("rnd word at edge %0d d=%b accepted", e, rd[e]);
    end
    load = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
